// File: rtl/multiword_adder_pkg.sv
// Shared types for the multi-word sequential adder: FSM state encoding.
package multiword_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiword_adder_seq_chunk_adder.sv
// N-bit combinational ripple-carry adder built from full-adder cells.
module chunk_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            assign s[gi]     = x[gi] ^ y[gi] ^ c[gi];
            assign c[gi + 1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign cout = c[N];

endmodule

// File: rtl/multiword_adder_seq.sv
// W-bit add/subtract (W = N*K) computed over K cycles by one shared N-bit
// adder, least-significant chunk first, with the inter-chunk carry registered.
module multiword_adder_seq
    import multiword_adder_pkg::*;
#(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [N*K-1:0]   a,
    input  logic [N*K-1:0]   b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [N*K-1:0]   s,
    output logic             cout,
    output logic             ovf
);

    localparam int W     = N * K;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             sub_reg;
    logic [W-1:0]     s_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [N-1:0]     chunk_x;
    logic [N-1:0]     chunk_y;
    logic [N-1:0]     chunk_sum;
    logic             chunk_cout;
    logic             accept;

    assign ready  = (state_reg == IDLE) || (state_reg == DONE);
    assign busy   = (state_reg == RUN);
    assign done   = (state_reg == DONE);
    assign s      = s_reg;
    assign cout   = cout_reg;
    assign ovf    = ovf_reg;
    assign accept = start && ready;

    // Subtraction is a + ~b + 1: the +1 comes from seeding the carry on accept.
    assign chunk_x = a_reg[idx_reg*N +: N];
    assign chunk_y = b_reg[idx_reg*N +: N] ^ {N{sub_reg}};

    chunk_adder #(
        .N (N)
    ) u_chunk_adder (
        .x    (chunk_x),
        .y    (chunk_y),
        .cin  (carry_reg),
        .s    (chunk_sum),
        .cout (chunk_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            sub_reg   <= sub;
            carry_reg <= sub ? 1'b1 : cin;
            idx_reg   <= '0;
            s_reg     <= '0;
            state_reg <= RUN;
        end else begin
            case (state_reg)
                RUN: begin
                    s_reg[idx_reg*N +: N] <= chunk_sum;
                    carry_reg             <= chunk_cout;
                    if (idx_reg == IDX_LAST) begin
                        cout_reg  <= chunk_cout;
                        ovf_reg   <= (chunk_x[N-1] == chunk_y[N-1]) &&
                                     (chunk_sum[N-1] != chunk_x[N-1]);
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Directed self-checking bench for multiword_adder_seq with N=4, K=4.
module tb_multiword_adder_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    int tests_run;
    int tests_failed;

    multiword_adder_seq #(
        .N (4),
        .K (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from IDLE and wait (bounded) for done.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv,
                         input logic tc, input logic ts,
                         output logic [15:0] rs, output logic rc, output logic ro,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        a = ta; b = tbv; cin = tc; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        rs = s; rc = cout; ro = ovf;
        $display("[TB] op a=%h b=%h cin=%0b sub=%0b -> s=%h cout=%0b ovf=%0b lat=%0d",
                 ta, tbv, tc, ts, rs, rc, ro, lat);
    endtask

    task automatic test_reset();
        logic [15:0] rs; logic rc, ro; int lat, bc;
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat, bc);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%0b exp=1", ready); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%0b exp=0", done); end
        tests_run++;
        if (s !== 16'h0000) begin tests_failed++; $display("FAIL reset_s got=%h exp=0000", s); end
        tests_run++;
        if (cout !== 1'b0) begin tests_failed++; $display("FAIL reset_cout got=%0b exp=0", cout); end
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_ripple();
        logic [15:0] rs; logic rc, ro; int lat, bc;
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat, bc);
        tests_run++;
        if (lat != 5) begin tests_failed++; $display("FAIL ripple_latency got=%0d exp=5", lat); end
        tests_run++;
        if (bc != 4) begin tests_failed++; $display("FAIL ripple_busy_cycles got=%0d exp=4", bc); end
        tests_run++;
        if (rs !== 16'h0100) begin tests_failed++; $display("FAIL ripple_s got=%h exp=0100", rs); end
        tests_run++;
        if (rc !== 1'b0 || ro !== 1'b0) begin tests_failed++; $display("FAIL ripple_flags got cout=%0b ovf=%0b exp 0/0", rc, ro); end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || ready !== 1'b1 || s !== 16'h0100) begin
            tests_failed++;
            $display("FAIL ripple_hold got done=%0b ready=%0b s=%h exp 0/1/0100", done, ready, s);
        end
    endtask

    task automatic test_add_boundaries();
        logic [15:0] rs; logic rc, ro; int lat, bc;
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat, bc);
        tests_run++;
        if (rs !== 16'h0000 || rc !== 1'b1 || ro !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_wrap got s=%h cout=%0b ovf=%0b exp 0000/1/0", rs, rc, ro);
        end
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat, bc);
        tests_run++;
        if (rs !== 16'h8000 || rc !== 1'b0 || ro !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_ovf got s=%h cout=%0b ovf=%0b exp 8000/0/1", rs, rc, ro);
        end
        do_op(16'h0000, 16'h0000, 1'b1, 1'b0, rs, rc, ro, lat, bc);
        tests_run++;
        if (rs !== 16'h0001 || rc !== 1'b0 || ro !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_cin got s=%h cout=%0b ovf=%0b exp 0001/0/0", rs, rc, ro);
        end
    endtask

    task automatic test_sub();
        logic [15:0] rs; logic rc, ro; int lat, bc;
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, rs, rc, ro, lat, bc);
        tests_run++;
        if (rs !== 16'hFFFE || rc !== 1'b0 || ro !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_borrow got s=%h cout=%0b ovf=%0b exp FFFE/0/0", rs, rc, ro);
        end
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, rs, rc, ro, lat, bc);
        tests_run++;
        if (rs !== 16'h0002 || rc !== 1'b1 || ro !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_noborrow got s=%h cout=%0b ovf=%0b exp 0002/1/0", rs, rc, ro);
        end
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, rs, rc, ro, lat, bc);
        tests_run++;
        if (rs !== 16'h7FFF || rc !== 1'b1 || ro !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_ovf got s=%h cout=%0b ovf=%0b exp 7FFF/1/1", rs, rc, ro);
        end
    endtask

    task automatic test_busy_ignored();
        int lat;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            if (lat == 2) begin
                a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        $display("[TB] busy-ignored op -> s=%h cout=%0b ovf=%0b lat=%0d", s, cout, ovf, lat);
        tests_run++;
        if (lat != 5) begin tests_failed++; $display("FAIL busy_ign_latency got=%0d exp=5", lat); end
        tests_run++;
        if (s !== 16'h2345 || cout !== 1'b0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ign_result got s=%h cout=%0b ovf=%0b exp 2345/0/0", s, cout, ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rs; logic rc, ro; int lat, bc;
        do_op(16'h0100, 16'h0200, 1'b0, 1'b0, rs, rc, ro, lat, bc);
        tests_run++;
        if (rs !== 16'h0300) begin tests_failed++; $display("FAIL b2b_first got=%h exp=0300", rs); end
        // done is high now; request the next op during the done cycle
        a = 16'h0010; b = 16'h0001; cin = 1'b0; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept got busy=%0b exp=1", busy); end
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        $display("[TB] back-to-back op -> s=%h cout=%0b ovf=%0b lat=%0d", s, cout, ovf, lat);
        tests_run++;
        if (lat != 5) begin tests_failed++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
        tests_run++;
        if (s !== 16'h000F || cout !== 1'b1 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second got s=%h cout=%0b ovf=%0b exp 000F/1/0", s, cout, ovf);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] rs; logic rc, ro; int lat, bc;
        int seen_done;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // two chunks processed, idx is now 2
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_state got busy=%0b ready=%0b done=%0b exp 0/1/0", busy, ready, done);
        end
        tests_run++;
        if (s !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_outputs got s=%h cout=%0b ovf=%0b exp 0000/0/0", s, cout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        tests_run++;
        if (seen_done != 0) begin tests_failed++; $display("FAIL midrun_no_done got=%0d exp=0", seen_done); end
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat, bc);
        tests_run++;
        if (rs !== 16'h0000 || rc !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrun_recover got s=%h cout=%0b exp 0000/1", rs, rc);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_add_ripple();
        test_add_boundaries();
        test_sub();
        test_busy_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
